// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave core and its pin synchronisers.
package spi_pkg;

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} spi_state_t;

   localparam int SPI_SYNC_DEPTH = 3;

   // Mode 0 and mode 3 sample on the rising SCK edge, modes 1 and 2 on the falling edge.
   function automatic logic spi_sample_on_rise(input logic cpol, input logic cpha);
      return cpol == cpha;
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin with edge detection on the last two stages.
module spi_edge_sync
   import spi_pkg::*;
#(
   parameter int   DEPTH   = SPI_SYNC_DEPTH,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [DEPTH-1:0] sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= {DEPTH{RST_VAL}};
      else       sync_q <= {sync_q[DEPTH-2:0], d_i};
   end

   assign level_o = sync_q[DEPTH-1];
   assign rise_o  =  sync_q[DEPTH-2] & ~sync_q[DEPTH-1];
   assign fall_o  = ~sync_q[DEPTH-2] &  sync_q[DEPTH-1];

endmodule

// File: rtl/spi_slave_core.sv
// Parameterised SPI slave: any CPOL/CPHA, DATA_W-bit words, multi-word frames,
// one-entry TX holding buffer and RX strobe with overrun/underrun status.
module spi_slave_core
   import spi_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter bit                CPOL      = 1'b0,
   parameter bit                CPHA      = 1'b0,
   parameter logic [DATA_W-1:0] IDLE_FILL = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              sck_i,
   input  logic              ssel_n_i,
   input  logic              mosi_i,
   output logic              miso_o,
   output logic              miso_oe_o,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   output logic              rx_overrun_o,
   input  logic              rx_ack_i,
   output logic              tx_underrun_o,
   output logic              busy_o
);

   localparam int               CNT_W       = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(DATA_W - 1);
   localparam logic             SAMPLE_RISE = spi_sample_on_rise(CPOL, CPHA);

   logic sck_lvl, sck_rise, sck_fall;
   logic ssel_lvl, ssel_rise, ssel_fall;

   spi_edge_sync #(.DEPTH(SPI_SYNC_DEPTH), .RST_VAL(CPOL)) u_sck_sync (
      .clk_i(clk_i), .rst_i(rst_i), .d_i(sck_i),
      .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
   );

   spi_edge_sync #(.DEPTH(SPI_SYNC_DEPTH), .RST_VAL(1'b1)) u_ssel_sync (
      .clk_i(clk_i), .rst_i(rst_i), .d_i(ssel_n_i),
      .level_o(ssel_lvl), .rise_o(ssel_rise), .fall_o(ssel_fall)
   );

   spi_state_t                state_q;
   logic [1:0]                mosi_q;
   logic [SPI_SYNC_DEPTH-1:0] settle_q;
   logic                      arm_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [DATA_W-1:0]         rx_shift_q, rx_data_q, tx_shift_q, buf_q;
   logic                      done_q, rx_valid_q, pending_q, overrun_q;
   logic                      buf_full_q, underrun_q;

   logic act, run, sample_ev, shift_ev, wrap, load, wr;

   always_comb begin
      act       = (state_q == IDLE) && arm_q && ssel_fall;
      run       = (state_q == ACTIVE) && !ssel_rise;
      sample_ev = run && (SAMPLE_RISE ? sck_rise : sck_fall);
      shift_ev  = run && (SAMPLE_RISE ? sck_fall : sck_rise);
      wrap      = sample_ev && (cnt_q == CNT_MAX);
      load      = (act && !CPHA) || (shift_ev && (cnt_q == '0));
      wr        = tx_valid_i && !buf_full_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         mosi_q     <= '0;
         settle_q   <= '0;
         arm_q      <= 1'b0;
         cnt_q      <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         tx_shift_q <= '0;
         buf_q      <= '0;
         done_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         pending_q  <= 1'b0;
         overrun_q  <= 1'b0;
         buf_full_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         mosi_q   <= {mosi_q[0], mosi_i};
         // A low ssel_n at reset release must not count as a frame start:
         // arm only once the bus has been seen idle after the chains settle.
         settle_q <= {settle_q[SPI_SYNC_DEPTH-2:0], 1'b1};
         arm_q    <= arm_q | (settle_q[SPI_SYNC_DEPTH-1] & ssel_lvl & (sck_lvl == CPOL));

         case (state_q)
            IDLE:    if (act)       state_q <= ACTIVE;
            ACTIVE:  if (ssel_rise) state_q <= IDLE;
            default:                state_q <= IDLE;
         endcase

         if (!run)           cnt_q <= '0;
         else if (sample_ev) cnt_q <= wrap ? '0 : cnt_q + 1'b1;

         if (sample_ev) rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_q[1]};

         done_q     <= wrap;
         rx_valid_q <= done_q;
         if (done_q) rx_data_q <= rx_shift_q;

         if (done_q)        pending_q <= 1'b1;
         else if (rx_ack_i) pending_q <= 1'b0;

         if (done_q && pending_q && !rx_ack_i) overrun_q <= 1'b1;
         else if (rx_ack_i)                    overrun_q <= 1'b0;

         if (load)          tx_shift_q <= buf_full_q ? buf_q : IDLE_FILL;
         else if (shift_ev) tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};

         underrun_q <= load && !buf_full_q;
         buf_full_q <= (buf_full_q && !load) || wr;
         if (wr) buf_q <= tx_data_i;
      end
   end

   assign miso_o        = tx_shift_q[DATA_W-1];
   assign miso_oe_o     = (state_q == ACTIVE);
   assign busy_o        = (state_q == ACTIVE);
   assign tx_ready_o    = !buf_full_q;
   assign rx_data_o     = rx_data_q;
   assign rx_valid_o    = rx_valid_q;
   assign rx_overrun_o  = overrun_q;
   assign tx_underrun_o = underrun_q;

endmodule
